// File: rtl/nx_fifo_rd_unpack.sv
// Unpacks each DATA_W-wide word from a show-ahead FIFO into two DATA_W/2 beats, low half first.
// Latency: a head word seen in IDLE is presented as the LO beat one cycle later; sustains 1 beat/cycle.
// Backpressure: out_ready=0 freezes the presented beat; the next word is popped only as the HI beat leaves.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   clear               synchronous flush of the holding register, FSM and frame counter
//   fifo_empty          upstream show-ahead FIFO empty flag
//   fifo_rdata          upstream head word (valid while fifo_empty=0)
//   fifo_ren            combinational pop of the upstream head word
//   out_valid/ready     output beat handshake
//   out_data            selected half of the holding register (0 when idle)
//   out_last            HI beat of the last word of a frame
//   word_idx            index of the current word within the frame
module nx_fifo_rd_unpack #(
  parameter int DATA_W      = 64,
  parameter int FRAME_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_rdata,
  output logic                fifo_ren,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W/2-1:0] out_data,
  output logic                out_last,
  output logic [3:0]          word_idx
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] hold_dat;
  logic [3:0]        idx_q;
  // Low while in reset and until the first edge after release, so no pop
  // can be requested before the block has seen a clean clock edge.
  logic              run;

  // Next-state and pop decision. A pop is only ever taken when the holding
  // register is free or is being freed this cycle by an accepted HI beat.
  always_comb begin
    fifo_ren  = 1'b0;
    state_nxt = state;
    if (run && !clear && !fifo_empty &&
        (state == ST_IDLE || (state == ST_HI && out_ready))) begin
      fifo_ren = 1'b1;
    end
    case (state)
      ST_IDLE: begin
        if (fifo_ren) state_nxt = ST_LO;
      end
      ST_LO: begin
        if (out_ready) state_nxt = ST_HI;
      end
      ST_HI: begin
        if (out_ready) state_nxt = fifo_ren ? ST_LO : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_dat <= '0;
      idx_q    <= 4'd0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (clear) begin
        state    <= ST_IDLE;
        hold_dat <= '0;
        idx_q    <= 4'd0;
      end else begin
        state <= state_nxt;
        if (fifo_ren) hold_dat <= fifo_rdata;
        // The frame position advances when the second half of a word leaves.
        if (state == ST_HI && out_ready) begin
          idx_q <= (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    case (state)
      ST_LO:   out_data = hold_dat[HALF_W-1:0];
      ST_HI:   out_data = hold_dat[DATA_W-1:HALF_W];
      default: out_data = '0;
    endcase
  end

  assign out_valid = (state == ST_LO) || (state == ST_HI);
  assign out_last  = (state == ST_HI) && (idx_q == LAST_IDX);
  assign word_idx  = idx_q;

endmodule

// File: tb/tb_nx_fifo_rd_unpack.sv
// Randomized and directed bench for nx_fifo_rd_unpack against a beat-queue reference model.
// Latency: checks every cycle at mid-period against the model's expected outputs.
// Backpressure: drives out_ready patterns (always-on, toggling, random) and an upstream FIFO queue.
module tb_nx_fifo_rd_unpack;

  localparam int DW = 64;
  localparam int F  = 8;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_ren;
  logic          out_valid;
  logic          out_ready;
  logic [DW/2-1:0] out_data;
  logic          out_last;
  logic [3:0]    word_idx;

  nx_fifo_rd_unpack #(.DATA_W(DW), .FRAME_WORDS(F)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .word_idx   (word_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the upstream FIFO contents, the beats still owed to the
  // output for already-popped words, and the count of completed words.
  typedef struct packed {
    logic        hi;
    logic [31:0] d;
  } beat_t;

  logic [DW-1:0] fifo_q[$];
  beat_t         pend[$];
  int            word_cnt;
  int            edges;     // rising edges seen since reset release
  int            errors;
  int            checks;

  // Observations of the DUT, gathered for section-level checks.
  int            obs_acc;
  int            obs_valid_cyc;
  logic [31:0]   obs_dat[$];
  int            obs_last_pos[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    word_cnt = 0;
    edges    = 0;
  endtask

  // One clock cycle: present FIFO head, check all outputs against the model
  // mid-cycle, then advance the model across the rising edge.
  task automatic step();
    logic          v;
    logic [31:0]   ed;
    logic          hi;
    logic [3:0]    idx;
    logic          last;
    logic          ren;
    logic [DW-1:0] w;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? {$urandom, $urandom} : fifo_q[0];
    #1;
    v    = !rst && pend.size() > 0;
    ed   = v ? pend[0].d : 32'd0;
    hi   = v && pend[0].hi;
    idx  = rst ? 4'd0 : 4'(word_cnt % F);
    last = hi && (idx == 4'(F - 1));
    ren  = !rst && !clear && edges >= 1 && fifo_q.size() > 0 &&
           (pend.size() == 0 || (pend.size() == 1 && out_ready));
    chk("out_valid", out_valid, v);
    chk("out_data", out_data, ed);
    chk("out_last", out_last, last);
    chk("word_idx", word_idx, idx);
    chk("fifo_ren", fifo_ren, ren);
    if (out_valid) obs_valid_cyc++;
    if (out_valid && out_ready && !clear) begin
      obs_acc++;
      obs_dat.push_back(out_data);
      if (out_last) obs_last_pos.push_back(obs_acc);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      edges++;
      if (clear) begin
        pend.delete();
        word_cnt = 0;
      end else begin
        if (v && out_ready) begin
          if (pend[0].hi) word_cnt++;
          void'(pend.pop_front());
        end
        if (ren) begin
          w = fifo_q.pop_front();
          pend.push_back({1'b0, w[31:0]});
          pend.push_back({1'b1, w[63:32]});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_acc       = 0;
    obs_valid_cyc = 0;
    obs_dat.delete();
    obs_last_pos.delete();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    clear      = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    model_reset();
    clear_obs();
    @(negedge clk);

    // Reset holds everything quiet even with a word waiting upstream.
    fifo_q.push_back(64'h1111_2222_3333_4444);
    out_ready = 1'b1;
    repeat (3) step();

    // Single word: LO then HI on consecutive cycles, frame index 0 -> 1.
    rst = 1'b0;
    clear_obs();
    repeat (6) step();
    chk("w1_beats", 64'(obs_acc), 64'd2);
    if (obs_dat.size() >= 2) begin
      chk("w1_lo", obs_dat[0], 64'h3333_4444);
      chk("w1_hi", obs_dat[1], 64'h1111_2222);
    end else begin
      chk("w1_present", 64'(obs_dat.size()), 64'd2);
    end
    chk("w1_idx", word_idx, 64'd1);

    // Sixteen words streamed with out_ready high: 32 back-to-back beats.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) fifo_q.push_back({$urandom, $urandom});
    clear_obs();
    repeat (40) step();
    chk("s16_beats", 64'(obs_acc), 64'd32);
    chk("s16_valid_cycles", 64'(obs_valid_cyc), 64'd32);
    chk("s16_last_cnt", 64'(obs_last_pos.size()), 64'd2);
    if (obs_last_pos.size() == 2) begin
      chk("s16_last0", 64'(obs_last_pos[0]), 64'd16);
      chk("s16_last1", 64'(obs_last_pos[1]), 64'd32);
    end
    chk("s16_idx_wrap", word_idx, 64'd0);

    // Toggling out_ready: every beat delivered exactly once, stable when stalled.
    for (int i = 0; i < 10; i++) fifo_q.push_back({$urandom, $urandom});
    clear_obs();
    for (int c = 0; c < 50; c++) begin
      out_ready = c[0];
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    chk("tog_beats", 64'(obs_acc), 64'd20);

    // Upstream empty for 20 cycles: nothing popped, nothing presented.
    for (int c = 0; c < 20; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Clear while presenting HI under backpressure; a waiting word is not popped.
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (pend.size() == 1) break;
      step();
    end
    chk("clr_in_hi", 64'(pend.size() == 1 && pend[0].hi), 64'd1);
    out_ready = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (6) step();

    // Asynchronous reset while presenting LO, then a clean restart.
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    out_ready = 1'b0;
    repeat (2) step();
    chk("ar_in_lo", 64'(pend.size() == 2), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 64'd0);
    chk("ar_data", out_data, 64'd0);
    chk("ar_ren", fifo_ren, 64'd0);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    // Random soak: random backpressure, arrivals and occasional clears.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) fifo_q.push_back({$urandom, $urandom});
      step();
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
